rr_stream_mux_arbiter: RTL

//   Shares one output stream between NUM_REQ requesters. Each requester offers

---
 rtl/rr_stream_mux_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin packet arbiter: locks a requester for a whole packet and steers its
// beats through an N:1 select into a single registered output stage.
module rr_stream_mux_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                grant_idx
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;

  logic [IDX_W-1:0]        rr_sel;
  logic [IDX_W-1:0]        sel;
  logic [IDX_W-1:0]        sel_inc;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    load_en;
  logic                    xfer;

  assign load_en = !out_valid_q || out_ready;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    rr_sel = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  end

  assign sel      = (state_q == LOCKED) ? lock_idx_q : rr_sel;
  assign sel_inc  = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
  assign sel_data = req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Ready/transfer generation, grant lock and output register load.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    grant_idx_d = grant_idx_q;
    req_ready   = '0;
    xfer        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) req_ready[sel] = load_en;
      end
      LOCKED: begin
        req_ready[sel] = load_en;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    xfer = req_valid[sel] && req_ready[sel];

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = req_last[sel];
      grant_idx_d = sel;
      if (req_last[sel]) begin
        state_d  = IDLE;
        rr_ptr_d = sel_inc;
      end else begin
        state_d    = LOCKED;
        lock_idx_d = sel;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_idx = grant_idx_q;

endmodule
